// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipelined RISC-V core: default widths, writeback
// source encodings and the EX/MEM payload record.
package riscv_pipe_pkg;

  localparam int DEFAULT_XLEN       = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_RSRC_W     = 2;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0]       alu_result;
    logic [DEFAULT_XLEN-1:0]       w_data;
    logic [DEFAULT_REG_ADDR_W-1:0] rd;
    logic [DEFAULT_XLEN-1:0]       pcplus4;
    logic                          reg_write;
    logic                          mem_write;
    logic [DEFAULT_RSRC_W-1:0]     result_src;
  } em_payload_t;

endpackage

// File: rtl/em_pipe_slot.sv
// One pipeline slot: a valid flag plus a payload register.
// Clear beats load for the flag; the payload only moves on an effective load.
module em_pipe_slot
  import riscv_pipe_pkg::*;
#(
  parameter type payload_t = em_payload_t
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     clear,
  input  payload_t d,
  output logic     valid,
  output payload_t q
);

  // NOTE: the payload is reset too, so the M outputs read 0 straight out of
  // reset rather than X; state is written with <= so every flop sees the
  // pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
        q     <= d;
      end
    end
  end

endmodule

// File: rtl/em_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush and control gating.
// Define EM_PIPE_SKID_EN to add a one-entry skid slot (registered in_ready).
module em_pipe_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int RSRC_W     = DEFAULT_RSRC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_resultE,
  input  logic [XLEN-1:0]       w_dataE,
  input  logic [REG_ADDR_W-1:0] rdE,
  input  logic [XLEN-1:0]       pcplus4E,
  input  logic                  reg_writeE,
  input  logic                  mem_writeE,
  input  logic [RSRC_W-1:0]     result_srcE,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_resultM,
  output logic [XLEN-1:0]       w_dataM,
  output logic [REG_ADDR_W-1:0] rdM,
  output logic [XLEN-1:0]       pcplus4M,
  output logic                  reg_writeM,
  output logic                  mem_writeM,
  output logic [RSRC_W-1:0]     result_srcM
);

  // Same layout as em_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       w_data;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pcplus4;
    logic                  reg_write;
    logic                  mem_write;
    logic [RSRC_W-1:0]     result_src;
  } payload_t;

  payload_t inBeat, mainD, mainQ;
  logic     mainValid, mainLoad, mainClear, mainFree, accept;

  assign inBeat = '{alu_result: alu_resultE, w_data: w_dataE, rd: rdE,
                    pcplus4: pcplus4E, reg_write: reg_writeE,
                    mem_write: mem_writeE, result_src: result_srcE};

  assign accept   = in_valid && in_ready;
  assign mainFree = !mainValid || out_ready;

`ifdef EM_PIPE_SKID_EN
  payload_t skidQ;
  logic     skidValid, skidLoad, skidClear;

  // in_ready depends only on the registered skid flag, never on out_ready.
  assign in_ready  = !skidValid;
  assign mainLoad  = !flush && mainFree && (skidValid || accept);
  assign mainD     = skidValid ? skidQ : inBeat;
  assign mainClear = flush || (mainValid && out_ready && !skidValid && !accept);
  // Accept is only possible with an empty skid, so a blocked main parks the beat.
  assign skidLoad  = !flush && accept && !mainFree;
  assign skidClear = flush || (skidValid && mainFree);

  em_pipe_slot #(.payload_t(payload_t)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skidLoad),
    .clear (skidClear),
    .d     (inBeat),
    .valid (skidValid),
    .q     (skidQ)
  );
`else
  assign in_ready  = mainFree;
  assign mainLoad  = !flush && accept;
  assign mainD     = inBeat;
  assign mainClear = flush || (mainValid && out_ready && !accept);
`endif

  em_pipe_slot #(.payload_t(payload_t)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mainLoad),
    .clear (mainClear),
    .d     (mainD),
    .valid (mainValid),
    .q     (mainQ)
  );

  assign out_valid   = mainValid;
  assign alu_resultM = mainQ.alu_result;
  assign w_dataM     = mainQ.w_data;
  assign rdM         = mainQ.rd;
  assign pcplus4M    = mainQ.pcplus4;
  assign result_srcM = mainQ.result_src;
  // A bubble or flushed beat must never write the register file or memory.
  assign reg_writeM  = mainQ.reg_write && mainValid;
  assign mem_writeM  = mainQ.mem_write && mainValid;

endmodule

// File: tb/tb_em_pipe_stage.sv
// Directed testbench for em_pipe_stage; expectations follow EM_PIPE_SKID_EN
// when the bench is built with that macro defined.
module tb_em_pipe_stage;
  import riscv_pipe_pkg::*;

`ifdef EM_PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] alu_resultE, w_dataE, pcplus4E, alu_resultM, w_dataM, pcplus4M;
  logic [4:0]  rdE, rdM;
  logic        reg_writeE, mem_writeE, reg_writeM, mem_writeM;
  logic [1:0]  result_srcE, result_srcM;

  int tests = 0;
  int fails = 0;

  em_pipe_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_resultE (alu_resultE),
    .w_dataE     (w_dataE),
    .rdE         (rdE),
    .pcplus4E    (pcplus4E),
    .reg_writeE  (reg_writeE),
    .mem_writeE  (mem_writeE),
    .result_srcE (result_srcE),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_resultM (alu_resultM),
    .w_dataM     (w_dataM),
    .rdM         (rdM),
    .pcplus4M    (pcplus4M),
    .reg_writeM  (reg_writeM),
    .mem_writeM  (mem_writeM),
    .result_srcM (result_srcM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        inv, ordy, flsh;
    logic [31:0] alu;
    logic        rw, mw;
    logic        exp_rdy, exp_v;
    logic [31:0] exp_alu;
    logic        exp_rw, exp_mw;
  } vec_t;

  vec_t vecs[9];

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Payload fields other than alu_result are derived from it: w_data = ~alu,
  // rd = alu[4:0], pcplus4 = alu + 4, result_src = RES_MEM.
  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [31:0] a, input logic rw, input logic mw);
    in_valid    = v;
    out_ready   = r;
    flush       = f;
    alu_resultE = a;
    w_dataE     = ~a;
    rdE         = a[4:0];
    pcplus4E    = a + 32'd4;
    reg_writeE  = rw;
    mem_writeE  = mw;
    result_srcE = RES_MEM;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic v, input logic [31:0] a,
                            input logic rw, input logic mw);
    check1({name, " out_valid"}, out_valid, v);
    check1({name, " reg_writeM"}, reg_writeM, rw);
    check1({name, " mem_writeM"}, mem_writeM, mw);
    if (v) begin
      check32({name, " alu_resultM"}, alu_resultM, a);
      check32({name, " w_dataM"}, w_dataM, ~a);
      check32({name, " rdM"}, {27'b0, rdM}, {27'b0, a[4:0]});
      check32({name, " pcplus4M"}, pcplus4M, a + 32'd4);
      check32({name, " result_srcM"}, {30'b0, result_srcM}, {30'b0, RES_MEM});
    end
  endtask

  initial begin
    vecs[0] = '{1, 1, 0, 32'h10, 1, 0, 1, 1, 32'h10, 1, 0};
    vecs[1] = '{1, 1, 0, 32'h20, 1, 0, 1, 1, 32'h20, 1, 0};
    vecs[2] = '{1, 1, 0, 32'h30, 1, 0, 1, 1, 32'h30, 1, 0};
    vecs[3] = '{0, 1, 0, 32'h00, 0, 0, 1, 0, 32'h00, 0, 0};
    vecs[4] = '{1, 1, 0, 32'h40, 0, 1, 1, 1, 32'h40, 0, 1};
    vecs[5] = '{0, 1, 0, 32'h00, 0, 0, 1, 0, 32'h00, 0, 0};
    vecs[6] = '{1, 0, 0, 32'h50, 1, 0, 1, 1, 32'h50, 1, 0};
    vecs[7] = '{0, 0, 0, 32'h00, 0, 0, SKID, 1, 32'h50, 1, 0};
    vecs[8] = '{0, 1, 0, 32'h00, 0, 0, 1, 0, 32'h00, 0, 0};

    // Reset held for 3 cycles under random stimulus.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      step();
      check1("rst out_valid", out_valid, 1'b0);
      check1("rst reg_writeM", reg_writeM, 1'b0);
      check1("rst mem_writeM", mem_writeM, 1'b0);
      check32("rst alu_resultM", alu_resultM, 32'h0);
      check32("rst w_dataM", w_dataM, 32'h0);
      check32("rst pcplus4M", pcplus4M, 32'h0);
      check32("rst rdM/result_srcM", {25'b0, rdM, result_srcM}, 32'h0);
    end
    drive(0, 1, 0, 32'h0, 0, 0);
    rst_n = 1'b1;
    #1;
    check1("rst in_ready", in_ready, 1'b1);

    // Table: streaming, drain, bubble gating, single-beat stall.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].inv, vecs[i].ordy, vecs[i].flsh, vecs[i].alu, vecs[i].rw, vecs[i].mw);
      #1;
      check1($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_rdy);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_alu,
                 vecs[i].exp_rw, vecs[i].exp_mw);
    end

    // Stall: first beat held 4 cycles, then a second beat offered.
    drive(1, 0, 0, 32'hAAAA_0001, 1, 0);
    #1;
    check1("stall load in_ready", in_ready, 1'b1);
    step();
    check_outs("stall load", 1, 32'hAAAA_0001, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 32'h0, 0, 0);
      #1;
      check1($sformatf("stall%0d in_ready", i), in_ready, SKID);
      step();
      check_outs($sformatf("stall%0d", i), 1, 32'hAAAA_0001, 1, 0);
    end
    drive(1, 0, 0, 32'hAAAA_0002, 1, 0);
    #1;
    check1("offer in_ready", in_ready, SKID);
    step();
    check_outs("offer", 1, 32'hAAAA_0001, 1, 0);
    check1("offer in_ready after", in_ready, 1'b0);
    if (SKID) drive(0, 1, 0, 32'h0, 0, 0);
    else      drive(1, 1, 0, 32'hAAAA_0002, 1, 0);
    #1;
    check1("release in_ready", in_ready, !SKID);
    step();
    check_outs("release", 1, 32'hAAAA_0002, 1, 0);
    check1("release in_ready after", in_ready, 1'b1);
    drive(0, 1, 0, 32'h0, 0, 0);
    step();
    check_outs("stall drain", 0, 32'h0, 0, 0);

    // Flush with a store in main and (skid build) a second beat parked.
    drive(1, 0, 0, 32'h2152_4110, 0, 1);  // w_dataE = 0xDEAD_BEEF
    step();
    check_outs("store", 1, 32'h2152_4110, 0, 1);
    drive(1, 0, 0, 32'h55, 0, 1);
    #1;
    check1("store2 in_ready", in_ready, SKID);
    step();
    check_outs("store2", 1, 32'h2152_4110, 0, 1);
    drive(0, 0, 1, 32'h0, 0, 0);
    step();
    check_outs("flush", 0, 32'h0, 0, 0);
    check1("flush in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h0, 0, 0);
      step();
      check_outs($sformatf("post flush%0d", i), 0, 32'h0, 0, 0);
    end

    // Flush overriding a simultaneous output and input handshake.
    drive(1, 0, 0, 32'h77, 1, 0);
    step();
    check_outs("pre flush2", 1, 32'h77, 1, 0);
    drive(1, 1, 1, 32'h88, 1, 0);
    #1;
    check1("flush2 in_ready", in_ready, 1'b1);
    step();
    check_outs("flush2", 0, 32'h0, 0, 0);
    check1("flush2 in_ready after", in_ready, 1'b1);
    drive(0, 1, 0, 32'h0, 0, 0);
    step();
    check_outs("post flush2", 0, 32'h0, 0, 0);

    // Asynchronous reset between clock edges while a beat is stalled.
    drive(1, 0, 0, 32'h99, 1, 1);
    step();
    check_outs("pre areset", 1, 32'h99, 1, 1);
    drive(0, 0, 0, 32'h0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check1("areset out_valid", out_valid, 1'b0);
    check1("areset reg_writeM", reg_writeM, 1'b0);
    check1("areset mem_writeM", mem_writeM, 1'b0);
    check32("areset alu_resultM", alu_resultM, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    check1("areset in_ready", in_ready, 1'b1);
    step();
    check_outs("post areset", 0, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/em_pipe_stage.md
Name: em_pipe_stage

Overview:
- Parametrised EX/MEM pipeline register for the pipelined RISC-V core, replacing the fixed 32-bit always-load register.
- Adds a valid/ready handshake, flush (bubble insertion) and gating of side-effecting controls on invalid beats.
- Adds an optional full-throughput skid buffer.
- Sits between the execute stage (E side) and the memory stage (M side).

Parameters:
- XLEN, 32, width of alu_result, w_data, pcplus4.
- REG_ADDR_W, 5, width of destination register index rd.
- RSRC_W, 2, width of result_src select.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  squash all held beats and any beat accepted this cycle.
- in_valid  in  1  E side presents a beat.
- in_ready  out  1  stage can accept a beat.
- alu_resultE  in  XLEN  ALU result.
- w_dataE  in  XLEN  store data.
- rdE  in  REG_ADDR_W  destination register.
- pcplus4E  in  XLEN  PC+4.
- reg_writeE  in  1  register-file write enable.
- mem_writeE  in  1  data-memory write enable.
- result_srcE  in  RSRC_W  writeback source select.
- out_valid  out  1  M side beat valid.
- out_ready  in  1  M side accepts the beat.
- alu_resultM, w_dataM, rdM, pcplus4M, result_srcM  out  matching widths  held payload.
- reg_writeM, mem_writeM  out  1  held controls, forced 0 whenever out_valid=0.

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all payload outputs 0; reg_writeM=mem_writeM=0; skid slot empty; in_ready=1 once the stage is empty.
- Accept: a beat transfers in when in_valid and in_ready are both 1 at a rising edge. It transfers out when out_valid and out_ready are both 1.
- Latency: 1 cycle. A beat accepted at edge N is visible on the M outputs after edge N.
- Main register: loads when (!out_valid || out_ready) and a source exists.
  - Source priority: the skid slot if occupied, else the input beat.
  - If neither exists, out_valid clears after a completed output transfer.
- Payload holds stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; the skid beat always exits before the input beat of the same cycle.
- Control gating: reg_writeM = stored reg_write & out_valid; same for mem_writeM. A bubble never writes the register file or memory.
- Flush:
  - Next edge: out_valid=0 and the skid slot is cleared.
  - A beat handshaken on the input in the flush cycle is discarded.
  - Flush overrides a simultaneous out_ready handshake; the output beat still counts as consumed.
  - Payload data registers may retain stale values; the controls read 0.
- in_valid=0 and out_ready=1 with a full main register: the stage drains to empty in 1 cycle.
- rst_n asserted mid-transfer: all state clears immediately, with no dependence on clk.

Optional Feature:
- Macro EM_PIPE_SKID_EN.
- Defined:
  - A one-entry skid slot is present.
  - in_ready = !skid_valid, a registered signal with no combinational path from out_ready.
  - When main is full, out_ready=0 and a beat is accepted, that beat goes to the skid slot.
  - Sustains 1 beat/cycle across single-cycle stalls.
- Undefined:
  - No skid slot.
  - in_ready = !out_valid || out_ready (combinational path from out_ready).
  - Identical ordering, flush and gating rules.

Decomposition:
- Package riscv_pipe_pkg holds:
  - XLEN and REG_ADDR_W defaults.
  - result_src encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - Packed struct em_payload_t of {alu_result, w_data, rd, pcplus4, reg_write, mem_write, result_src}.
- Sub-module em_pipe_slot: one valid flag plus em_payload_t register with load/clear.
  - Instantiated once for main.
  - Instantiated a second time for the skid slot under EM_PIPE_SKID_EN.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> out_valid=0, all M outputs 0, in_ready=1 after release.
- Streaming: out_ready=1; drive beats alu_resultE=0x10,0x20,0x30 with reg_writeE=1 back to back -> alu_resultM shows 0x10,0x20,0x30 on consecutive cycles, 1-cycle latency, reg_writeM=1 each cycle.
- Stall: beat 0xAAAA_0001 held with out_ready=0 for 4 cycles, then a second beat 0xAAAA_0002 offered.
  - Outputs stay stable at 0x...01.
  - With skid: in_ready drops only after 0x...02 is captured; order is 01 then 02 on release.
  - Without skid: in_ready=0 throughout the stall.
- Flush: a store beat (mem_writeE=1, w_dataE=0xDEAD_BEEF) sits in main, another is accepted, and flush=1 -> next cycle out_valid=0, mem_writeM=0, neither beat ever appears.
- Flush with simultaneous out_ready=1 and in_valid=1 -> the accepted input is dropped; the stage is empty next cycle.
- Async reset mid-stall: pull rst_n low between clock edges while out_valid=1 -> out_valid, reg_writeM and mem_writeM go 0 immediately, before the next clk edge.
